cu_sequencer: RTL and testbench
===============================

// Module: cu_sequencer
// PURPOSE
//  Multicycle control unit that drives the FU and register file: fetches 16-bit
//  instructions, decodes them and issues fs codes and register selects to the FU.
//  Consumes the FU z/n flags for branches. Sits between instruction/data memory
//  and the datapath (register file + FU + MB/MD muxes) in mycpu.
// PARAMETERS
//  PC_W      16   program counter / instruction address width
//  RESET_PC  0    PC value loaded at reset
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  run_in       in   1     1 = allowed to start a new fetch
//  imem_req     out  1     instruction read request, held until imem_ack
//  imem_addr    out  PC_W  instruction address (= pc)
//  imem_ack     in   1     instruction valid this cycle
//  imem_rdata   in   16    instruction word
//  dmem_req     out  1     data access request, held until dmem_ack
//  dmem_we      out  1     1 = store, 0 = load (valid with dmem_req)
//  dmem_ack     in   1     data access complete (load data valid on MD bus)
//  rf_dr        out  3     destination register
//  rf_sa        out  3     A-bus source register (also data address)
//  rf_sb        out  3     B-bus source register (also store data)
//  rf_we        out  1     register file write enable, one cycle pulse
//  fs_out       out  4     FU function select (fs_t encoding)
//  mb_const     out  1     1 = B bus takes const_out instead of R[sb]
//  const_out    out  16    zero-extended immediate
//  md_sel       out  1     1 = write-back from memory, 0 = from FU
//  z_in, n_in   in   1     FU zero / negative flags, combinational from fs_out
//  halted       out  1     1 = HALT executed, sticky until reset
// BEHAVIOUR
//  Format: ir[15:14] class, ir[13:10] fs/sub, ir[8:6] dr, ir[5:3] sa, ir[2:0] sb;
//   ir[9] reserved, ignored. imm6/off6 = ir[5:0].
//  Classes: 00 ALU R[dr]<=FU(fs,R[sa],R[sb]); 01 LDI R[dr]<=zext(imm6) via FMOVB;
//   10 MEM ir[13]=0 LD R[dr]<=M[R[sa]], ir[13]=1 ST M[R[sa]]<=R[sb];
//   11 BR ir[13:12] 00 always, 01 if z, 10 if n, 11 HALT; flags from FMOVA on R[sa].
//  States: IDLE, FETCH, DECODE, EXEC, MEM_WAIT, HALT.
//  Reset: state=IDLE, pc=RESET_PC, ir=0; all outputs 0 except imem_addr=RESET_PC.
//  IDLE: run_in=1 -> FETCH next cycle; else stay.
//  FETCH: imem_req=1; on imem_ack: ir<=imem_rdata, pc<=pc+1 (wraps mod 2^PC_W), -> DECODE.
//  DECODE: one cycle, fields registered; no enables asserted.
//  EXEC: ALU/LDI: rf_we=1 for exactly this cycle -> FETCH (or IDLE if run_in=0).
//   BR: fs_out=FMOVA, rf_sa=sa; taken -> pc<=pc+sext(off6) (pc already +1), else pc
//   unchanged; -> FETCH/IDLE. HALT -> HALT state, halted=1, no further requests.
//   MEM -> MEM_WAIT (no request in EXEC).
//  MEM_WAIT: dmem_req=1, dmem_we=ir[13]; LD also drives md_sel=1; on dmem_ack LD pulses
//   rf_we=1 that same cycle, then -> FETCH/IDLE. dmem_req drops the cycle after ack.
//  Latency: ALU/LDI/BR = fetch wait + 3 cycles; MEM = fetch wait + 3 + dmem wait.
//  Acks arriving while no matching request is outstanding are ignored.
//  run_in deasserted mid-instruction: instruction completes, then IDLE.
//  rst_n low at any time (incl. mid-handshake): immediate return to reset values.
//  Outputs are registered-state decoded; no combinational path imem_ack->imem_req.
// STRUCTURE
//  mycpu_pkg: cu_state_t, op_class_t, br_cond_t, instruction field constants; reuse fs_t.
//  Sub-module cu_decode: combinational ir -> field/control decode; FSM+PC in top.
// TESTING
//  Reset, run_in=1, imem_ack next cycle with 16'h0A4B (ALU FADD dr1 sa1 sb3)
//   -> rf_we=1 in EXEC with fs_out=2, rf_dr=1, rf_sa=1, rf_sb=3; pc=1.
//  LDI 16'h4145 -> mb_const=1, const_out=16'h0005, fs_out=FMOVB, rf_dr=5, rf_we=1.
//  LD 16'h8088 with dmem_ack after 3 cycles -> dmem_req held 3 cycles, dmem_we=0,
//   rf_we+md_sel only in ack cycle; ST 16'hA008 -> dmem_we=1, no rf_we.
//  BR-if-z at pc=4, off6=6'h3E (-2), z_in=1 -> next imem_addr=3; z_in=0 -> 5.
//  pc=16'hFFFF fetch -> pc wraps to 0; HALT 16'hF000 -> halted=1, imem_req stays 0.
//  rst_n low during MEM_WAIT -> dmem_req=0 same cycle, state IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu control unit.
//  cu_state_t  : sequencer FSM states
//  op_class_t  : instruction class held in ir[15:14]
//  br_cond_t   : branch condition held in ir[13:12] (11 = HALT)
//  fs_t        : FU function-select encoding
//  Field position constants describe the 16-bit instruction layout.
package mycpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_HALT     = 3'd5
  } cu_state_t;

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_LDI = 2'b01,
    CLS_MEM = 2'b10,
    CLS_BR  = 2'b11
  } op_class_t;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_Z      = 2'b01,
    BR_N      = 2'b10,
    BR_HALT   = 2'b11
  } br_cond_t;

  // FU function codes; ALU-class instructions carry these directly in ir[13:10].
  typedef enum logic [3:0] {
    FMOVA = 4'b0000,
    FINC  = 4'b0001,
    FADD  = 4'b0010,
    FSUB  = 4'b0101,
    FDEC  = 4'b0110,
    FAND  = 4'b1000,
    FOR   = 4'b1001,
    FXOR  = 4'b1010,
    FNOT  = 4'b1011,
    FMOVB = 4'b1100,
    FSHR  = 4'b1101,
    FSHL  = 4'b1110
  } fs_t;

  localparam int IR_CLASS_LSB = 14;
  localparam int IR_FS_LSB    = 10;
  localparam int IR_STORE_BIT = 13;
  localparam int IR_COND_LSB  = 12;
  localparam int IR_DR_LSB    = 6;
  localparam int IR_SA_LSB    = 3;
  localparam int IR_SB_LSB    = 0;
  localparam int IMM_W        = 6;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decode for cu_sequencer.
//  ir        in   16    latched instruction word
//  op_class  out  2     instruction class (op_class_t)
//  fs        out  4     FU function for ALU class
//  dr/sa/sb  out  3     register selects
//  imm       out  16    zero-extended imm6
//  off       out  PC_W  sign-extended off6
//  br_cond   out  2     branch condition (br_cond_t)
//  is_store  out  1     MEM class: 1 = store, 0 = load
module cu_decode
  import mycpu_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [15:0]     ir,
  output logic [1:0]      op_class,
  output logic [3:0]      fs,
  output logic [2:0]      dr,
  output logic [2:0]      sa,
  output logic [2:0]      sb,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] off,
  output logic [1:0]      br_cond,
  output logic            is_store
);

  // ir[9] is reserved and deliberately ignored.
  logic unused_ir9;
  assign unused_ir9 = ir[9];

  assign op_class = ir[IR_CLASS_LSB +: 2];
  assign fs       = ir[IR_FS_LSB +: 4];
  assign dr       = ir[IR_DR_LSB +: 3];
  assign sa       = ir[IR_SA_LSB +: 3];
  assign sb       = ir[IR_SB_LSB +: 3];
  assign br_cond  = ir[IR_COND_LSB +: 2];
  assign is_store = ir[IR_STORE_BIT];
  assign imm      = {{(16-IMM_W){1'b0}}, ir[IMM_W-1:0]};
  assign off      = {{(PC_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

endmodule

// File: rtl/cu_sequencer.sv
// Multicycle control unit: fetches 16-bit instructions, decodes them and
// drives FU function selects, register selects and memory handshakes.
//  clk, rst_n             clock, async active-low reset
//  run_in                 permits starting a new fetch
//  imem_req/addr/ack/rdata instruction fetch handshake (req held until ack)
//  dmem_req/we/ack        data access handshake (req held until ack)
//  rf_dr/sa/sb/we         register file controls (we is a one-cycle pulse)
//  fs_out, mb_const,
//  const_out, md_sel      datapath steering
//  z_in, n_in             FU flags used by conditional branches
//  halted                 sticky after HALT until reset
//  dbg_state              current FSM state (cu_state_t encoding)
// Handshakes: a request is raised from registered state and held until the
// matching ack is seen on a rising edge; acks with no request pending are
// ignored. Requests never depend combinationally on their own ack.
module cu_sequencer
  import mycpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_in,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic [2:0]      rf_dr,
  output logic [2:0]      rf_sa,
  output logic [2:0]      rf_sb,
  output logic            rf_we,
  output logic [3:0]      fs_out,
  output logic            mb_const,
  output logic [15:0]     const_out,
  output logic            md_sel,
  input  logic            z_in,
  input  logic            n_in,
  output logic            halted,
  output logic [2:0]      dbg_state
);

  cu_state_t       state, state_nx;
  logic [PC_W-1:0] pc, pc_nx;
  logic [15:0]     ir, ir_nx;

  logic [1:0]      d_class;
  logic [3:0]      d_fs;
  logic [2:0]      d_dr, d_sa, d_sb;
  logic [15:0]     d_imm;
  logic [PC_W-1:0] d_off;
  logic [1:0]      d_cond;
  logic            d_store;
  logic            br_taken;
  cu_state_t       done_state;

  cu_decode #(.PC_W(PC_W)) u_decode (
    .ir       (ir),
    .op_class (d_class),
    .fs       (d_fs),
    .dr       (d_dr),
    .sa       (d_sa),
    .sb       (d_sb),
    .imm      (d_imm),
    .off      (d_off),
    .br_cond  (d_cond),
    .is_store (d_store)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
    end
  end

  assign imem_addr = pc;
  assign dbg_state = state;

  always_comb begin
    br_taken = 1'b0;
    case (d_cond)
      BR_ALWAYS: br_taken = 1'b1;
      BR_Z:      br_taken = z_in;
      BR_N:      br_taken = n_in;
      default:   br_taken = 1'b0;
    endcase
  end

  // Where an instruction goes once it retires: stop if run_in was dropped.
  assign done_state = run_in ? S_FETCH : S_IDLE;

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_nx     = ir;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_dr     = 3'd0;
    rf_sa     = 3'd0;
    rf_sb     = 3'd0;
    rf_we     = 1'b0;
    fs_out    = FMOVA;
    mb_const  = 1'b0;
    const_out = 16'd0;
    md_sel    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_in) state_nx = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_nx    = imem_rdata;
          pc_nx    = pc + PC_W'(1);
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        case (d_class)
          CLS_ALU: begin
            fs_out   = d_fs;
            rf_dr    = d_dr;
            rf_sa    = d_sa;
            rf_sb    = d_sb;
            rf_we    = 1'b1;
            state_nx = done_state;
          end
          CLS_LDI: begin
            fs_out    = FMOVB;
            rf_dr     = d_dr;
            mb_const  = 1'b1;
            const_out = d_imm;
            rf_we     = 1'b1;
            state_nx  = done_state;
          end
          CLS_MEM: begin
            rf_sa    = d_sa;
            rf_sb    = d_sb;
            state_nx = S_MEM_WAIT;
          end
          default: begin
            if (d_cond == BR_HALT) begin
              state_nx = S_HALT;
            end else begin
              // Flags come from passing R[sa] through the FU unchanged.
              fs_out = FMOVA;
              rf_sa  = d_sa;
              // pc already points past the branch, so the offset is relative to pc+1.
              if (br_taken) pc_nx = pc + d_off;
              state_nx = done_state;
            end
          end
        endcase
      end
      S_MEM_WAIT: begin
        dmem_req = 1'b1;
        dmem_we  = d_store;
        rf_sa    = d_sa;
        rf_sb    = d_sb;
        if (!d_store) rf_dr = d_dr;
        if (dmem_ack) begin
          // Load data is on the MD bus only in the ack cycle; write it back then.
          if (!d_store) begin
            rf_we  = 1'b1;
            md_sel = 1'b1;
          end
          state_nx = done_state;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cu_sequencer.sv
module tb_cu_sequencer;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_DECODE   = 3'd2;
  localparam logic [2:0] ST_EXEC     = 3'd3;
  localparam logic [2:0] ST_MEM_WAIT = 3'd4;
  localparam logic [2:0] ST_HALT     = 3'd5;
  localparam logic [3:0] FS_MOVA     = 4'b0000;
  localparam logic [3:0] FS_ADD      = 4'b0010;
  localparam logic [3:0] FS_MOVB     = 4'b1100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_in;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [2:0]  rf_dr, rf_sa, rf_sb;
  logic        rf_we;
  logic [3:0]  fs_out;
  logic        mb_const;
  logic [15:0] const_out;
  logic        md_sel;
  logic        z_in, n_in;
  logic        halted;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  cu_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_in     (run_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_dr      (rf_dr),
    .rf_sa      (rf_sa),
    .rf_sb      (rf_sb),
    .rf_we      (rf_we),
    .fs_out     (fs_out),
    .mb_const   (mb_const),
    .const_out  (const_out),
    .md_sel     (md_sel),
    .z_in       (z_in),
    .n_in       (n_in),
    .halted     (halted),
    .dbg_state  (dbg_state)
  );

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick;
    @(negedge clk);
  endtask

  // Wait (bounded) for a fetch request, check its address, optionally stall,
  // then acknowledge with the given word. Returns at the DECODE negedge.
  task automatic do_fetch(input string tag, input logic [15:0] exp_addr,
                          input logic [15:0] word, input int wait_n);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_req"}, imem_req, 1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    for (int i = 0; i < wait_n; i++) begin
      tick;
      check({tag, "_req_held"}, imem_req, 1);
    end
    imem_rdata = word;
    imem_ack   = 1'b1;
    tick;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    check({tag, "_decode"}, dbg_state, ST_DECODE);
  endtask

  initial begin
    rst_n = 1'b0; run_in = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
    dmem_ack = 1'b0; z_in = 1'b0; n_in = 1'b0;
    repeat (2) tick;

    // reset values
    check("rst_imem_req", imem_req, 0);
    check("rst_imem_addr", imem_addr, 16'h0000);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_halted", halted, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_const", const_out, 0);

    rst_n = 1'b1;
    repeat (2) tick;
    check("idle_hold", dbg_state, ST_IDLE);
    // ack without request must be ignored
    imem_ack = 1'b1; imem_rdata = 16'hF000;
    tick;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    check("spur_ack_state", dbg_state, ST_IDLE);
    check("spur_ack_pc", imem_addr, 16'h0000);

    // ALU FADD dr1 sa1 sb3
    run_in = 1'b1;
    do_fetch("alu", 16'h0000, 16'h0A4B, 0);
    check("alu_dec_we", rf_we, 0);
    check("alu_pc", imem_addr, 16'h0001);
    tick;
    check("alu_we", rf_we, 1);
    check("alu_fs", fs_out, FS_ADD);
    check("alu_dr", rf_dr, 1);
    check("alu_sa", rf_sa, 1);
    check("alu_sb", rf_sb, 3);
    check("alu_mb", mb_const, 0);
    tick;
    check("alu_we_pulse", rf_we, 0);

    // LDI dr5 imm 5, with one stall cycle on fetch
    do_fetch("ldi", 16'h0001, 16'h4145, 1);
    tick;
    check("ldi_mb", mb_const, 1);
    check("ldi_const", const_out, 16'h0005);
    check("ldi_fs", fs_out, FS_MOVB);
    check("ldi_dr", rf_dr, 5);
    check("ldi_we", rf_we, 1);
    tick;

    // LD dr2 <- M[R1], ack on third request cycle
    do_fetch("ld", 16'h0002, 16'h8088, 0);
    tick;
    check("ld_exec_req", dmem_req, 0);
    check("ld_exec_we", rf_we, 0);
    tick;
    for (int i = 0; i < 2; i++) begin
      check("ld_wait_req", dmem_req, 1);
      check("ld_wait_we", dmem_we, 0);
      check("ld_wait_rfwe", rf_we, 0);
      check("ld_wait_md", md_sel, 0);
      tick;
    end
    dmem_ack = 1'b1;
    #1;
    check("ld_ack_req", dmem_req, 1);
    check("ld_ack_rfwe", rf_we, 1);
    check("ld_ack_md", md_sel, 1);
    check("ld_ack_dr", rf_dr, 2);
    check("ld_ack_sa", rf_sa, 1);
    tick;
    dmem_ack = 1'b0;
    check("ld_req_drop", dmem_req, 0);
    check("ld_next", dbg_state, ST_FETCH);

    // ST M[R1] <- R0
    do_fetch("st", 16'h0003, 16'hA008, 0);
    tick;
    tick;
    dmem_ack = 1'b1;
    #1;
    check("st_req", dmem_req, 1);
    check("st_we", dmem_we, 1);
    check("st_rfwe", rf_we, 0);
    check("st_md", md_sel, 0);
    tick;
    dmem_ack = 1'b0;

    // BR if z, off -2, taken: 5 - 2 = 3
    do_fetch("brz1", 16'h0004, 16'hD03E, 0);
    z_in = 1'b1;
    tick;
    check("br_fs", fs_out, FS_MOVA);
    check("br_sa", rf_sa, 7);
    check("br_rfwe", rf_we, 0);
    tick;
    z_in = 1'b0;
    do_fetch("nop3", 16'h0003, 16'h0000, 0);
    tick;
    tick;
    // same branch, not taken: falls through to 5
    do_fetch("brz0", 16'h0004, 16'hD03E, 0);
    tick;
    tick;
    // BR if n, off +2, taken: 6 + 2 = 8
    do_fetch("brn", 16'h0005, 16'hE002, 0);
    n_in = 1'b1;
    tick;
    tick;
    n_in = 1'b0;
    // BR always, off -10: 9 - 10 = FFFF
    do_fetch("bra", 16'h0008, 16'hC036, 0);
    tick;
    tick;
    do_fetch("wrap", 16'hFFFF, 16'h0000, 0);
    check("wrap_pc", imem_addr, 16'h0000);
    tick;
    tick;

    // HALT
    do_fetch("halt", 16'h0000, 16'hF000, 0);
    tick;
    check("halt_exec_we", rf_we, 0);
    tick;
    check("halt_flag", halted, 1);
    check("halt_state", dbg_state, ST_HALT);
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("halt_no_req", imem_req, 0);
      check("halt_sticky", halted, 1);
    end
    imem_ack = 1'b0;

    // reset clears halt; then run_in dropped mid-instruction
    rst_n = 1'b0;
    #1;
    check("rst2_halted", halted, 0);
    check("rst2_state", dbg_state, ST_IDLE);
    tick;
    rst_n = 1'b1;
    do_fetch("rd", 16'h0000, 16'h0A4B, 0);
    run_in = 1'b0;
    tick;
    check("rd_exec_we", rf_we, 1);
    tick;
    check("rd_idle", dbg_state, ST_IDLE);
    check("rd_no_req", imem_req, 0);
    tick;
    check("rd_idle_hold", dbg_state, ST_IDLE);

    // reset in the middle of a data handshake
    run_in = 1'b1;
    do_fetch("rstld", 16'h0001, 16'h8088, 0);
    tick;
    tick;
    check("rstld_req", dmem_req, 1);
    check("rstld_state", dbg_state, ST_MEM_WAIT);
    rst_n = 1'b0;
    #1;
    check("rstld_req_drop", dmem_req, 0);
    check("rstld_idle", dbg_state, ST_IDLE);
    check("rstld_pc", imem_addr, 16'h0000);
    check("rstld_halted", halted, 0);
    tick;
    rst_n = 1'b1;
    tick;

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
